codec_intf: RTL

CODEC_INTF -- requirements
Module: codec_intf

---
 rtl/codec_pkg.sv | 28 ++
 rtl/codec_clk_gen.sv | 38 +++
 rtl/codec_intf.sv | 92 +++++++++
 3 files changed

// File: rtl/codec_pkg.sv
// Shared constants and event-strobe bundle for the audio codec serial interface.
package codec_pkg;

  localparam int CNT_W  = 10;
  localparam int SMPL_W = 16;

  localparam int LRCLK_BIT = 9;
  localparam int SCLK_BIT  = 4;
  localparam int MCLK_BIT  = 1;
  localparam int PH_W      = SCLK_BIT + 1;

  localparam logic [PH_W-1:0]  RX_SHIFT_PH = 5'd18;
  localparam logic [PH_W-1:0]  TX_SHIFT_PH = 5'd31;
  localparam logic [CNT_W-1:0] CNT_SHADOW  = 10'd500;
  localparam logic [CNT_W-1:0] CNT_TX_RHT  = 10'd511;
  localparam logic [CNT_W-1:0] CNT_VLD     = 10'd1011;
  localparam logic [CNT_W-1:0] CNT_WRAP    = 10'd1023;

  typedef struct packed {
    logic rx_shift;
    logic tx_shift;
    logic shadow;
    logic tx_rht;
    logic vld;
    logic wrap;
  } codec_ev_t;

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter: produces LRCLK/SCLK/MCLK straight from counter
// flops and decodes the datapath event strobes.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  output logic      o_lrclk,
  output logic      o_sclk,
  output logic      o_mclk,
  output codec_ev_t o_ev
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + 1'b1;
  end

  assign o_lrclk = r_cnt[LRCLK_BIT];
  assign o_sclk  = r_cnt[SCLK_BIT];
  assign o_mclk  = r_cnt[MCLK_BIT];

  // NOTE: combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    o_ev          = '0;
    o_ev.rx_shift = (r_cnt[PH_W-1:0] == RX_SHIFT_PH);
    o_ev.tx_shift = (r_cnt[PH_W-1:0] == TX_SHIFT_PH);
    o_ev.shadow   = (r_cnt == CNT_SHADOW);
    o_ev.tx_rht   = (r_cnt == CNT_TX_RHT);
    o_ev.vld      = (r_cnt == CNT_VLD);
    o_ev.wrap     = (r_cnt == CNT_WRAP);
  end

endmodule

// File: rtl/codec_intf.sv
// Left-justified 16-bit stereo codec interface: serial capture, paired playback
// and codec reset sequencing. Define CODEC_LOOPBACK_EN to replay received samples.
module codec_intf
  import codec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SMPL_W-1:0] lft_out,
  input  logic [SMPL_W-1:0] rht_out,
  input  logic              SDout,
  output logic [SMPL_W-1:0] lft_in,
  output logic [SMPL_W-1:0] rht_in,
  output logic              vld,
  output logic              LRCLK,
  output logic              SCLK,
  output logic              MCLK,
  output logic              RSTn,
  output logic              SDin
);

  codec_ev_t         w_ev;
  logic              r_sync1, r_sync2;
  logic [SMPL_W-1:0] r_rx_sr, r_lft_shadow;
  logic [SMPL_W-1:0] r_lft_in, r_rht_in;
  logic              r_vld, r_rstn;
  logic [SMPL_W-1:0] r_tx_sr, r_rht_hold;
  logic [SMPL_W-1:0] w_tx_lft_src, w_tx_rht_src;

  codec_clk_gen u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_lrclk (LRCLK),
    .o_sclk  (SCLK),
    .o_mclk  (MCLK),
    .o_ev    (w_ev)
  );

`ifdef CODEC_LOOPBACK_EN
  assign w_tx_lft_src = r_lft_in;
  assign w_tx_rht_src = r_rht_in;
`else
  assign w_tx_lft_src = lft_out;
  assign w_tx_rht_src = rht_out;
`endif

  // Receive: sampling two clks after SCLK rises absorbs the synchronizer delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_rx_sr      <= '0;
      r_lft_shadow <= '0;
      r_lft_in     <= '0;
      r_rht_in     <= '0;
      r_vld        <= 1'b0;
    end else begin
      r_sync1 <= SDout;
      r_sync2 <= r_sync1;
      if (w_ev.rx_shift) r_rx_sr <= {r_rx_sr[SMPL_W-2:0], r_sync2};
      if (w_ev.shadow)   r_lft_shadow <= r_rx_sr;
      if (w_ev.vld) begin
        r_lft_in <= r_lft_shadow;
        r_rht_in <= r_rx_sr;
      end
      r_vld <= w_ev.vld & r_rstn;
    end
  end

  // Transmit: right sample is held at frame start so the pair plays together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sr    <= '0;
      r_rht_hold <= '0;
      r_rstn     <= 1'b0;
    end else if (w_ev.wrap) begin
      r_tx_sr    <= w_tx_lft_src;
      r_rht_hold <= w_tx_rht_src;
      r_rstn     <= 1'b1;
    end else if (w_ev.tx_rht) begin
      r_tx_sr <= r_rht_hold;
    end else if (w_ev.tx_shift) begin
      r_tx_sr <= {r_tx_sr[SMPL_W-2:0], 1'b0};
    end
  end

  assign lft_in = r_lft_in;
  assign rht_in = r_rht_in;
  assign vld    = r_vld;
  assign RSTn   = r_rstn;
  assign SDin   = r_tx_sr[SMPL_W-1];

endmodule
